// File: rtl/rgb_hue_sequencer_pkg.sv
// Shared definitions for the RGB hue sequencer.
// Holds the colour-wheel segment encoding, the step-pending state type and
// the segment-advance helper used by the sequencer and its neighbours.
package rgb_hue_sequencer_pkg;

  localparam int unsigned SPEED_BITS = 2;
  localparam int unsigned SEG_BITS   = 3;

  // Colour-wheel segments: red->yellow, yellow->green, ... magenta->red
  typedef enum logic [SEG_BITS-1:0] {
    SEG_RY = 3'd0,
    SEG_YG = 3'd1,
    SEG_GC = 3'd2,
    SEG_CB = 3'd3,
    SEG_BM = 3'd4,
    SEG_MR = 3'd5
  } seg_e;

  localparam seg_e SEG_LAST = SEG_MR;

  // A wheel step has been requested by the prescaler but not yet applied
  typedef enum logic {
    PEND_IDLE = 1'b0,
    PEND_SET  = 1'b1
  } pend_e;

  // Next segment around the wheel, wrapping after the last one
  function automatic seg_e seg_next(seg_e s);
    if (s == SEG_LAST) begin
      return SEG_RY;
    end
    return seg_e'(SEG_BITS'(s) + SEG_BITS'(1));
  endfunction

endpackage

// File: rtl/rgb_hue_sequencer_if.sv
// Control/duty bus between the PWM stage and the hue sequencer.
//   master : drives enable, speed, brightness, period_end; receives duties
//   slave  : the sequencer side
//   enable      wheel advance enable
//   speed       rate select
//   brightness  global scale
//   period_end  PWM final-count strobe
//   duty_r/g/b  channel duty words
//   duty_valid  pulse when duty words reload
//   segment     current wheel segment
interface rgb_hue_sequencer_if
  import rgb_hue_sequencer_pkg::*;
#(
  parameter int unsigned DUTY_BITS = 8
) ();

  logic                  enable;
  logic [SPEED_BITS-1:0] speed;
  logic [DUTY_BITS-1:0]  brightness;
  logic                  period_end;
  logic [DUTY_BITS-1:0]  duty_r;
  logic [DUTY_BITS-1:0]  duty_g;
  logic [DUTY_BITS-1:0]  duty_b;
  logic                  duty_valid;
  logic [SEG_BITS-1:0]   segment;

  modport master (
    output enable, speed, brightness, period_end,
    input  duty_r, duty_g, duty_b, duty_valid, segment
  );

  modport slave (
    input  enable, speed, brightness, period_end,
    output duty_r, duty_g, duty_b, duty_valid, segment
  );

endinterface

// File: rtl/rgb_hue_sequencer_tick_prescaler.sv
// Wheel-step rate prescaler.
//   clk, reset_n : clock, async active-low reset
//   enable       : count when high, freeze counter when low
//   speed        : terminal count = (TICK_DIV >> speed) - 1
//   tick         : combinational one-cycle step request at terminal count
module tick_prescaler
  import rgb_hue_sequencer_pkg::*;
#(
  parameter int unsigned TICK_DIV = 390625
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic [SPEED_BITS-1:0] speed,
  output logic                  tick
);

  localparam int unsigned PRESC_BITS = $clog2(TICK_DIV);

  logic [PRESC_BITS-1:0] presc_q;
  logic [PRESC_BITS-1:0] presc_d;
  logic [31:0]           term;

  // >= rather than == so a faster speed takes effect without a wrap
  always_comb begin
    presc_d = presc_q;
    tick    = 1'b0;
    term    = 32'(TICK_DIV >> speed) - 32'd1;
    if (enable) begin
      if (32'(presc_q) >= term) begin
        tick    = 1'b1;
        presc_d = '0;
      end else begin
        presc_d = presc_q + PRESC_BITS'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

endmodule

// File: rtl/rgb_hue_sequencer.sv
// RGB hue sequencer: walks a six-segment colour wheel and produces scaled
// R/G/B duty words for the PWM channels, reloading only at PWM period end.
//   clk      : system clock
//   reset_n  : async active-low reset
//   bus      : slave side of rgb_hue_sequencer_if (controls in, duties out)
module rgb_hue_sequencer
  import rgb_hue_sequencer_pkg::*;
#(
  parameter int unsigned DUTY_BITS = 8,
  parameter int unsigned TICK_DIV  = 390625
) (
  input  logic                clk,
  input  logic                reset_n,
  rgb_hue_sequencer_if.slave  bus
);

  localparam int unsigned          PROD_BITS = 2 * DUTY_BITS + 1;
  localparam logic [DUTY_BITS-1:0] DUTY_MAX  = {DUTY_BITS{1'b1}};

  typedef struct packed {
    logic [DUTY_BITS-1:0] r;
    logic [DUTY_BITS-1:0] g;
    logic [DUTY_BITS-1:0] b;
  } rgb_t;

  logic                 tick;
  logic                 do_step;
  pend_e                pend_q,  pend_d;
  seg_e                 seg_q,   seg_d;
  logic [DUTY_BITS-1:0] ramp_q,  ramp_d;
  rgb_t                 duty_q,  duty_d;
  logic                 valid_q, valid_d;
  logic [DUTY_BITS-1:0] up;
  logic [DUTY_BITS-1:0] dn;
  rgb_t                 raw;
  rgb_t                 scaled;

  // (v * (br + 1)) >> DUTY_BITS: br = MAX passes v through unchanged
  function automatic logic [DUTY_BITS-1:0] scale(logic [DUTY_BITS-1:0] v,
                                                 logic [DUTY_BITS-1:0] br);
    logic [PROD_BITS-1:0] prod;
    prod = PROD_BITS'(v) * (PROD_BITS'(br) + PROD_BITS'(1));
    return DUTY_BITS'(prod >> DUTY_BITS);
  endfunction

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk     (clk),
    .reset_n (reset_n),
    .enable  (bus.enable),
    .speed   (bus.speed),
    .tick    (tick)
  );

  // Pending/step next state: ticks coalesce into one step per period end
  always_comb begin
    pend_d  = pend_q;
    seg_d   = seg_q;
    ramp_d  = ramp_q;
    do_step = 1'b0;
    if (bus.period_end) begin
      pend_d  = PEND_IDLE;
      do_step = (pend_q == PEND_SET) || tick;
    end else if (tick) begin
      pend_d  = PEND_SET;
    end
    if (do_step) begin
      if (ramp_q == DUTY_MAX - DUTY_BITS'(1)) begin
        ramp_d = '0;
        seg_d  = seg_next(seg_q);
      end else begin
        ramp_d = ramp_q + DUTY_BITS'(1);
      end
    end
  end

  // Raw colour of the post-step position, so the reload shows this step
  always_comb begin
    up  = ramp_d;
    dn  = DUTY_MAX - ramp_d;
    raw = '0;
    case (seg_d)
      SEG_RY:  begin raw.r = DUTY_MAX; raw.g = up;       raw.b = '0;       end
      SEG_YG:  begin raw.r = dn;       raw.g = DUTY_MAX; raw.b = '0;       end
      SEG_GC:  begin raw.r = '0;       raw.g = DUTY_MAX; raw.b = up;       end
      SEG_CB:  begin raw.r = '0;       raw.g = dn;       raw.b = DUTY_MAX; end
      SEG_BM:  begin raw.r = up;       raw.g = '0;       raw.b = DUTY_MAX; end
      SEG_MR:  begin raw.r = DUTY_MAX; raw.g = '0;       raw.b = dn;       end
      default: raw = '0;
    endcase
  end

  // Brightness scaling, one multiplier per channel
  always_comb begin
    scaled.r = scale(raw.r, bus.brightness);
    scaled.g = scale(raw.g, bus.brightness);
    scaled.b = scale(raw.b, bus.brightness);
  end

  // Output reload on every period end, stepped or not
  always_comb begin
    duty_d  = duty_q;
    valid_d = 1'b0;
    if (bus.period_end) begin
      duty_d  = scaled;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_q  <= PEND_IDLE;
      seg_q   <= SEG_RY;
      ramp_q  <= '0;
      duty_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      pend_q  <= pend_d;
      seg_q   <= seg_d;
      ramp_q  <= ramp_d;
      duty_q  <= duty_d;
      valid_q <= valid_d;
    end
  end

  assign bus.duty_r     = duty_q.r;
  assign bus.duty_g     = duty_q.g;
  assign bus.duty_b     = duty_q.b;
  assign bus.duty_valid = valid_q;
  assign bus.segment    = SEG_BITS'(seg_q);

endmodule

// File: tb/tb_rgb_hue_sequencer.sv
// Bench for rgb_hue_sequencer (DUTY_BITS=8, TICK_DIV=8): scoreboard of
// expected duty reloads, a brightness vector table and hand-written
// sequences for reset, coalescing, wrap, enable freeze and speed change.
module tb_rgb_hue_sequencer;

  typedef struct {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic [2:0] seg;
  } exp_t;

  typedef struct {
    logic [7:0] br;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n;
  int   n_tests   = 0;
  int   n_fail    = 0;
  int   valid_cnt = 0;
  exp_t sb_q[$];
  vec_t vecs[5];

  rgb_hue_sequencer_if #(.DUTY_BITS(8)) bus ();

  rgb_hue_sequencer #(
    .DUTY_BITS (8),
    .TICK_DIV  (8)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic exp_t mk(int r, int g, int b, int seg);
    exp_t e;
    e.r   = 8'(r);
    e.g   = 8'(g);
    e.b   = 8'(b);
    e.seg = 3'(seg);
    return e;
  endfunction

  // Full-brightness colour after n wheel steps from reset
  function automatic exp_t wheel(int n);
    int s;
    int p;
    s = (n / 255) % 6;
    p = n % 255;
    case (s)
      0:       return mk(255, p, 0, s);
      1:       return mk(255 - p, 255, 0, s);
      2:       return mk(0, 255, p, s);
      3:       return mk(0, 255 - p, 255, s);
      4:       return mk(p, 0, 255, s);
      default: return mk(255, 0, 255 - p, s);
    endcase
  endfunction

  // Scoreboard: every duty_valid must match the oldest pending expectation
  always @(negedge clk) begin
    if (reset_n === 1'b1 && bus.duty_valid === 1'b1) begin
      exp_t e;
      valid_cnt++;
      if (sb_q.size() == 0) begin
        chk("unexpected_valid", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        chk("sb_duty_r", bus.duty_r, e.r);
        chk("sb_duty_g", bus.duty_g, e.g);
        chk("sb_duty_b", bus.duty_b, e.b);
        chk("sb_segment", bus.segment, e.seg);
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, %0d expectations pending", sb_q.size());
    $fatal(1, "watchdog");
  end

  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(exp_t e);
    sb_q.push_back(e);
    bus.period_end = 1'b1;
    step_clk();
    bus.period_end = 1'b0;
  endtask

  // Period end lands on the prescaler terminal cycle (presc starts at 0)
  task automatic aligned_step(int n);
    repeat (7) step_clk();
    pulse(wheel(n));
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step_clk();
    step_clk();
    reset_n = 1'b1;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb_q.size() != 0; i++) step_clk();
    step_clk();
    chk("sb_drain", sb_q.size(), 0);
  endtask

  initial begin
    int v0;
    reset_n        = 1'b0;
    bus.enable     = 1'b0;
    bus.speed      = 2'd0;
    bus.brightness = 8'd255;
    bus.period_end = 1'b0;
    step_clk();
    step_clk();

    // 1: reset values, mid-run async reset, first reload after release
    chk("rst_duty_r", bus.duty_r, 0);
    chk("rst_duty_g", bus.duty_g, 0);
    chk("rst_duty_b", bus.duty_b, 0);
    chk("rst_valid", bus.duty_valid, 0);
    chk("rst_segment", bus.segment, 0);
    reset_n    = 1'b1;
    bus.enable = 1'b1;
    for (int n = 1; n <= 3; n++) aligned_step(n);
    drain();
    chk("pre_rst_duty_g", bus.duty_g, 3);
    #2;
    reset_n = 1'b0;
    #1;
    chk("midrst_duty_r", bus.duty_r, 0);
    chk("midrst_duty_g", bus.duty_g, 0);
    chk("midrst_valid", bus.duty_valid, 0);
    chk("midrst_segment", bus.segment, 0);
    step_clk();
    reset_n    = 1'b1;
    bus.enable = 1'b0;
    pulse(mk(255, 0, 0, 0));
    chk("first_valid_hi", bus.duty_valid, 1);
    chk("first_duty_r", bus.duty_r, 255);
    step_clk();
    chk("first_valid_lo", bus.duty_valid, 0);
    drain();

    // 2: five ticks per period end coalesce into a single step
    do_reset();
    bus.enable = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      repeat (39) step_clk();
      pulse(mk(255, k, 0, 0));
    end
    drain();

    // 3: aligned stepping through a segment boundary and a full wheel
    do_reset();
    bus.enable = 1'b1;
    for (int n = 1; n <= 1530; n++) begin
      aligned_step(n);
      if (n == 255) begin
        chk("seg1_segment", bus.segment, 1);
        chk("seg1_duty_r", bus.duty_r, 255);
        chk("seg1_duty_g", bus.duty_g, 255);
      end
    end
    chk("wrap_segment", bus.segment, 0);
    chk("wrap_duty_r", bus.duty_r, 255);
    chk("wrap_duty_g", bus.duty_g, 0);
    chk("wrap_duty_b", bus.duty_b, 0);
    bus.enable = 1'b0;
    drain();

    // 4: brightness scaling at raw (255,128,0)
    do_reset();
    bus.enable = 1'b1;
    for (int n = 1; n <= 128; n++) aligned_step(n);
    bus.enable = 1'b0;
    vecs[0] = '{br: 8'd127, r: 8'd127, g: 8'd64,  b: 8'd0};
    vecs[1] = '{br: 8'd0,   r: 8'd0,   g: 8'd0,   b: 8'd0};
    vecs[2] = '{br: 8'd63,  r: 8'd63,  g: 8'd32,  b: 8'd0};
    vecs[3] = '{br: 8'd1,   r: 8'd1,   g: 8'd1,   b: 8'd0};
    vecs[4] = '{br: 8'd255, r: 8'd255, g: 8'd128, b: 8'd0};
    for (int i = 0; i < 5; i++) begin
      bus.brightness = vecs[i].br;
      pulse(mk(vecs[i].r, vecs[i].g, vecs[i].b, 0));
      step_clk();
    end
    bus.brightness = 8'd127;
    pulse(mk(127, 64, 0, 0));
    bus.brightness = 8'd255;
    repeat (3) step_clk();
    chk("hold_duty_r", bus.duty_r, 127);
    chk("hold_duty_g", bus.duty_g, 64);
    chk("hold_valid", bus.duty_valid, 0);
    pulse(mk(255, 128, 0, 0));
    drain();

    // 5: frozen wheel reloads every period end, then resumes from held presc
    bus.enable = 1'b1;
    repeat (3) step_clk();
    bus.enable = 1'b0;
    v0 = valid_cnt;
    for (int i = 0; i < 100; i++) begin
      step_clk();
      step_clk();
      pulse(mk(255, 128, 0, 0));
    end
    drain();
    chk("frozen_valid_count", valid_cnt - v0, 100);
    chk("frozen_duty_g", bus.duty_g, 128);
    bus.enable = 1'b1;
    repeat (4) step_clk();
    pulse(mk(255, 129, 0, 0));
    bus.enable = 1'b0;
    drain();

    // 6: speed 0->3 with presc=5 ticks at once, then every cycle
    do_reset();
    bus.enable = 1'b1;
    bus.speed  = 2'd0;
    repeat (5) step_clk();
    bus.speed = 2'd3;
    step_clk();
    for (int k = 1; k <= 10; k++) pulse(mk(255, k, 0, 0));
    bus.enable = 1'b0;
    bus.speed  = 2'd0;
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
